// File: rtl/contador_pkg.sv
// Shared types and seven-segment constants for the MM:SS counter.
// Segment bit order is {g,f,e,d,c,b,a}; constants are active-low (0 = lit).
package contador_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] bcd_to_seg_al(input bcd_t d);
        logic [6:0] p;
        case (d)
            4'd0:    p = SEG_0;
            4'd1:    p = SEG_1;
            4'd2:    p = SEG_2;
            4'd3:    p = SEG_3;
            4'd4:    p = SEG_4;
            4'd5:    p = SEG_5;
            4'd6:    p = SEG_6;
            4'd7:    p = SEG_7;
            4'd8:    p = SEG_8;
            4'd9:    p = SEG_9;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// One BCD digit to a registered seven-segment pattern, polarity selectable.
// Reset shows "0" so the display never flashes garbage.
module bcd_to_7seg
    import contador_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  bcd_t       digit_i,
    output logic [6:0] seg_o
);

    logic [6:0] seg_q;
    logic [6:0] seg_d;
    logic [6:0] pat_al;

    always_comb begin
        pat_al = bcd_to_seg_al(digit_i);
        seg_d  = ACTIVE_LOW ? pat_al : ~pat_al;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= ACTIVE_LOW ? SEG_0 : ~SEG_0;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign seg_o = seg_q;

endmodule

// File: rtl/contador_mmss_param.sv
// MM:SS counter with run/pause, up/down counting, validated BCD preset,
// tick prescaler and registered seven-segment outputs.
module contador_mmss_param
    import contador_pkg::*;
#(
    parameter int TICK_DIV       = 50_000_000,
    parameter int MIN_MAX        = 99,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       up_ndown,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    output logic [6:0] sec1,
    output logic [6:0] sec2,
    output logic [6:0] min1,
    output logic [6:0] min2,
    output logic       running,
    output logic       done,
    output logic       wrap,
    output logic       load_err,
    output state_t     state_dbg
);

    localparam int         PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);
    localparam bcd_t       MM_T       = bcd_t'(MIN_MAX / 10);
    localparam bcd_t       MM_U       = bcd_t'(MIN_MAX % 10);
    localparam logic [7:0] MM_VAL     = 8'(MIN_MAX);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    bcd_t          s1_q, s1_d, s2_q, s2_d, m1_q, m1_d, m2_q, m2_d;
    logic          done_q, done_d, wrap_q, wrap_d, load_err_q, load_err_d;

    logic          digits_zero;
    logic [7:0]    load_min_val;
    logic          load_ok;

    assign digits_zero  = ({m2_q, m1_q, s2_q, s1_q} == 16'h0000);
    assign load_min_val = ({4'd0, load_min[7:4]} * 8'd10) + {4'd0, load_min[3:0]};
    assign load_ok      = (load_min[7:4] <= 4'd9) && (load_min[3:0] <= 4'd9) &&
                          (load_sec[7:4] <= 4'd5) && (load_sec[3:0] <= 4'd9) &&
                          (load_min_val <= MM_VAL);

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        m1_d       = m1_q;
        m2_d       = m2_q;
        done_d     = 1'b0;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;

        if (clear) begin
            s1_d    = '0;
            s2_d    = '0;
            m1_d    = '0;
            m2_d    = '0;
            presc_d = '0;
            state_d = ST_IDLE;
        end else if (load) begin
            presc_d = '0;
            if (load_ok) begin
                s1_d = load_sec[3:0];
                s2_d = load_sec[7:4];
                m1_d = load_min[3:0];
                m2_d = load_min[7:4];
            end else begin
                load_err_d = 1'b1;
            end
            if (state_q == ST_DONE) state_d = ST_IDLE;
        end else if (stop) begin
            // Prescaler is left alone so the tick phase survives a pause.
            if (state_q == ST_RUN) state_d = ST_IDLE;
        end else if (start && state_q == ST_IDLE) begin
            if (!up_ndown && digits_zero) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end else if (state_q == ST_RUN) begin
            if (presc_q != TICK_LAST) begin
                presc_d = presc_q + PRESC_ONE;
            end else begin
                presc_d = '0;
                if (up_ndown) begin
                    if (s1_q != 4'd9) begin
                        s1_d = s1_q + 4'd1;
                    end else begin
                        s1_d = '0;
                        if (s2_q != 4'd5) begin
                            s2_d = s2_q + 4'd1;
                        end else begin
                            s2_d = '0;
                            if (m2_q == MM_T && m1_q == MM_U) begin
                                m1_d   = '0;
                                m2_d   = '0;
                                wrap_d = 1'b1;
                            end else if (m1_q == 4'd9) begin
                                m1_d = '0;
                                m2_d = m2_q + 4'd1;
                            end else begin
                                m1_d = m1_q + 4'd1;
                            end
                        end
                    end
                end else if (digits_zero) begin
                    // Switched to down while sitting at 00:00: finish at once.
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    if (s1_q != 4'd0) begin
                        s1_d = s1_q - 4'd1;
                    end else begin
                        s1_d = 4'd9;
                        if (s2_q != 4'd0) begin
                            s2_d = s2_q - 4'd1;
                        end else begin
                            s2_d = 4'd5;
                            if (m1_q != 4'd0) begin
                                m1_d = m1_q - 4'd1;
                            end else begin
                                m1_d = 4'd9;
                                m2_d = m2_q - 4'd1;
                            end
                        end
                    end
                    if ({m2_d, m1_d, s2_d, s1_d} == 16'h0000) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            m1_q       <= '0;
            m2_q       <= '0;
            done_q     <= 1'b0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            m1_q       <= m1_d;
            m2_q       <= m2_d;
            done_q     <= done_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign running   = (state_q == ST_RUN);
    assign done      = done_q;
    assign wrap      = wrap_q;
    assign load_err  = load_err_q;
    assign state_dbg = state_q;

    bcd_to_7seg #(.ACTIVE_LOW(SEG_ACTIVE_LOW != 0)) u_seg_s1 (
        .clk(clk), .rst_n(rst_n), .digit_i(s1_q), .seg_o(sec1));
    bcd_to_7seg #(.ACTIVE_LOW(SEG_ACTIVE_LOW != 0)) u_seg_s2 (
        .clk(clk), .rst_n(rst_n), .digit_i(s2_q), .seg_o(sec2));
    bcd_to_7seg #(.ACTIVE_LOW(SEG_ACTIVE_LOW != 0)) u_seg_m1 (
        .clk(clk), .rst_n(rst_n), .digit_i(m1_q), .seg_o(min1));
    bcd_to_7seg #(.ACTIVE_LOW(SEG_ACTIVE_LOW != 0)) u_seg_m2 (
        .clk(clk), .rst_n(rst_n), .digit_i(m2_q), .seg_o(min2));

endmodule

// File: tb/tb_contador_mmss_param.sv
// Bench for contador_mmss_param: two instances (MIN_MAX 99 active-low, MIN_MAX 2
// active-high) share stimulus and are checked against a total-seconds model.
module tb_contador_mmss_param;

    localparam int TD = 4;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;
    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0, stop = 1'b0, clear = 1'b0, up_ndown = 1'b1, load = 1'b0;
    logic [7:0] load_min = 8'h00, load_sec = 8'h00;

    logic [6:0] sec1_w[2], sec2_w[2], min1_w[2], min2_w[2];
    logic       running_w[2], done_w[2], wrap_w[2], lerr_w[2];
    logic [1:0] st_dbg_w[2];

    int checks = 0;
    int failures = 0;

    // Model: time held as total seconds, state as a small integer.
    int         mt[2], mst[2], mpr[2];
    int         mmax[2] = '{99, 2};
    bit         mal[2]  = '{1'b1, 1'b0};
    string      nm[2]   = '{"a", "b"};
    logic [6:0] mseg[2][4];
    logic       mdone[2], mwrap[2], mlerr[2];

    always #5 clk = ~clk;

    contador_mmss_param #(.TICK_DIV(TD), .MIN_MAX(99), .SEG_ACTIVE_LOW(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
        .up_ndown(up_ndown), .load(load), .load_min(load_min), .load_sec(load_sec),
        .sec1(sec1_w[0]), .sec2(sec2_w[0]), .min1(min1_w[0]), .min2(min2_w[0]),
        .running(running_w[0]), .done(done_w[0]), .wrap(wrap_w[0]),
        .load_err(lerr_w[0]), .state_dbg(st_dbg_w[0]));

    contador_mmss_param #(.TICK_DIV(TD), .MIN_MAX(2), .SEG_ACTIVE_LOW(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
        .up_ndown(up_ndown), .load(load), .load_min(load_min), .load_sec(load_sec),
        .sec1(sec1_w[1]), .sec2(sec2_w[1]), .min1(min1_w[1]), .min2(min2_w[1]),
        .running(running_w[1]), .done(done_w[1]), .wrap(wrap_w[1]),
        .load_err(lerr_w[1]), .state_dbg(st_dbg_w[1]));

    function automatic logic [6:0] enc(input int t, input int j, input bit al);
        int sec, mins, d;
        logic [6:0] p;
        sec  = t % 60;
        mins = t / 60;
        case (j)
            0:       d = sec % 10;
            1:       d = sec / 10;
            2:       d = mins % 10;
            default: d = mins / 10;
        endcase
        p = SEG_TAB[d];
        return al ? p : ~p;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mt[k] = 0; mst[k] = M_IDLE; mpr[k] = 0;
            mdone[k] = 1'b0; mwrap[k] = 1'b0; mlerr[k] = 1'b0;
            for (int j = 0; j < 4; j++) mseg[k][j] = enc(0, j, mal[k]);
        end
    endtask

    task automatic model_step(input int k);
        int mins, secs, period;
        bit ok;
        for (int j = 0; j < 4; j++) mseg[k][j] = enc(mt[k], j, mal[k]);
        mdone[k] = 1'b0; mwrap[k] = 1'b0; mlerr[k] = 1'b0;
        period = (mmax[k] + 1) * 60;
        if (clear) begin
            mt[k] = 0; mpr[k] = 0; mst[k] = M_IDLE;
        end else if (load) begin
            mpr[k] = 0;
            mins = int'(load_min[7:4]) * 10 + int'(load_min[3:0]);
            secs = int'(load_sec[7:4]) * 10 + int'(load_sec[3:0]);
            ok = (load_min[7:4] <= 9) && (load_min[3:0] <= 9) && (load_sec[7:4] <= 5) &&
                 (load_sec[3:0] <= 9) && (mins <= mmax[k]);
            if (ok) mt[k] = mins * 60 + secs;
            else    mlerr[k] = 1'b1;
            if (mst[k] == M_DONE) mst[k] = M_IDLE;
        end else if (stop) begin
            if (mst[k] == M_RUN) mst[k] = M_IDLE;
        end else if (start && mst[k] == M_IDLE) begin
            if (!up_ndown && mt[k] == 0) begin
                mst[k] = M_DONE; mdone[k] = 1'b1;
            end else begin
                mst[k] = M_RUN;
            end
        end else if (mst[k] == M_RUN) begin
            if (mpr[k] < TD - 1) begin
                mpr[k]++;
            end else begin
                mpr[k] = 0;
                if (up_ndown) begin
                    mt[k] = (mt[k] + 1) % period;
                    if (mt[k] == 0) mwrap[k] = 1'b1;
                end else begin
                    if (mt[k] > 0) mt[k]--;
                    if (mt[k] == 0) begin
                        mst[k] = M_DONE; mdone[k] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk({nm[k], " sec1"}, {1'b0, sec1_w[k]}, {1'b0, mseg[k][0]});
            chk({nm[k], " sec2"}, {1'b0, sec2_w[k]}, {1'b0, mseg[k][1]});
            chk({nm[k], " min1"}, {1'b0, min1_w[k]}, {1'b0, mseg[k][2]});
            chk({nm[k], " min2"}, {1'b0, min2_w[k]}, {1'b0, mseg[k][3]});
            chk({nm[k], " running"}, {7'd0, running_w[k]}, {7'd0, mst[k] == M_RUN});
            chk({nm[k], " done"}, {7'd0, done_w[k]}, {7'd0, mdone[k]});
            chk({nm[k], " wrap"}, {7'd0, wrap_w[k]}, {7'd0, mwrap[k]});
            chk({nm[k], " load_err"}, {7'd0, lerr_w[k]}, {7'd0, mlerr[k]});
        end
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_all();
    endtask

    task automatic pulse_load(input logic [7:0] mn, input logic [7:0] sc);
        load_min = mn; load_sec = sc; load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    int cnt_a, cnt_b;

    initial begin
        #1 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Count up one minute.
        up_ndown = 1'b1;
        start = 1'b1; cycle(); start = 1'b0;
        repeat (60 * TD) cycle();
        stop = 1'b1; cycle(); stop = 1'b0;
        cycle();
        chk("a min1 one minute", {1'b0, min1_w[0]}, {1'b0, 7'b1111001});
        chk("a sec1 one minute", {1'b0, sec1_w[0]}, {1'b0, 7'b1000000});
        chk("b min1 one minute", {1'b0, min1_w[1]}, {1'b0, 7'b0000110});

        // Roll-over at the minute ceiling (b) and plain carry (a).
        clear = 1'b1; cycle(); clear = 1'b0;
        pulse_load(8'h02, 8'h59);
        start = 1'b1; cycle(); start = 1'b0;
        cnt_a = 0; cnt_b = 0;
        repeat (6) begin
            cycle();
            cnt_a += int'(wrap_w[0]);
            cnt_b += int'(wrap_w[1]);
        end
        chk("b wrap count", 8'(cnt_b), 8'd1);
        chk("a wrap count", 8'(cnt_a), 8'd0);
        stop = 1'b1; cycle(); stop = 1'b0;

        // Count down to completion, then sit in DONE.
        clear = 1'b1; cycle(); clear = 1'b0;
        up_ndown = 1'b0;
        pulse_load(8'h00, 8'h02);
        start = 1'b1; cycle(); start = 1'b0;
        cnt_a = 0; cnt_b = 0;
        repeat (5 * TD) begin
            cycle();
            cnt_a += int'(done_w[0]);
            cnt_b += int'(done_w[1]);
        end
        chk("a done count", 8'(cnt_a), 8'd1);
        chk("b done count", 8'(cnt_b), 8'd1);
        chk("a running after done", {7'd0, running_w[0]}, 8'd0);
        start = 1'b1; cycle(); start = 1'b0;
        chk("a start ignored in done", {7'd0, running_w[0]}, 8'd0);

        // Rejected loads leave the digits alone.
        pulse_load(8'h00, 8'h60);
        chk("a load_err sec 60", {7'd0, lerr_w[0]}, 8'd1);
        pulse_load(8'h1A, 8'h00);
        chk("a load_err min 1A", {7'd0, lerr_w[0]}, 8'd1);
        pulse_load(8'h05, 8'h00);
        chk("b load_err min 05", {7'd0, lerr_w[1]}, 8'd1);
        chk("a load accepted", {7'd0, lerr_w[0]}, 8'd0);
        cycle();

        // Pause keeps prescaler phase.
        clear = 1'b1; cycle(); clear = 1'b0;
        up_ndown = 1'b1;
        start = 1'b1; cycle(); start = 1'b0;
        cycle(); cycle();
        stop = 1'b1; cycle(); stop = 1'b0;
        repeat (10) cycle();
        start = 1'b1; cycle(); start = 1'b0;
        cycle(); cycle();
        chk("a sec1 before tick shows", {1'b0, sec1_w[0]}, {1'b0, 7'b1000000});
        cycle();
        chk("a sec1 after resumed tick", {1'b0, sec1_w[0]}, {1'b0, 7'b1111001});
        clear = 1'b1; start = 1'b1; cycle(); clear = 1'b0; start = 1'b0;
        chk("a clear beats start", {7'd0, running_w[0]}, 8'd0);
        cycle();
        chk("a sec1 after clear", {1'b0, sec1_w[0]}, {1'b0, 7'b1000000});

        // Randomized command mix.
        repeat (800) begin
            clear    = ($urandom_range(0, 49) == 0);
            load     = ($urandom_range(0, 24) == 0);
            stop     = ($urandom_range(0, 14) == 0);
            start    = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) up_ndown = ~up_ndown;
            if ($urandom_range(0, 1) == 0) begin
                load_min = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                load_sec = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            end else begin
                load_min = 8'($urandom_range(0, 255));
                load_sec = 8'($urandom_range(0, 255));
            end
            cycle();
        end
        clear = 1'b0; load = 1'b0; stop = 1'b0; start = 1'b0;

        // Asynchronous reset in the middle of a run.
        up_ndown = 1'b1;
        pulse_load(8'h01, 8'h34);
        start = 1'b1; cycle(); start = 1'b0;
        repeat (20) cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("a sec1 async reset", {1'b0, sec1_w[0]}, {1'b0, 7'b1000000});
        chk("a sec2 async reset", {1'b0, sec2_w[0]}, {1'b0, 7'b1000000});
        chk("a min1 async reset", {1'b0, min1_w[0]}, {1'b0, 7'b1000000});
        chk("a min2 async reset", {1'b0, min2_w[0]}, {1'b0, 7'b1000000});
        chk("b sec1 async reset", {1'b0, sec1_w[1]}, {1'b0, 7'b0111111});
        chk("a running async reset", {7'd0, running_w[0]}, 8'd0);
        chk("b running async reset", {7'd0, running_w[1]}, 8'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1; cycle(); start = 1'b0;
        repeat (2 * TD + 2) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/contador_mmss_param.md
# contador_mmss_param

Parametrised minute:second counter with four seven-segment digit outputs: next generation of the board's free-running MM:SS display counter. Adds run/pause control, count-up or count-down mode, BCD preset load with validation, a configurable tick divisor and minute ceiling, and completion/wrap events. Sits between the board clock and the four seven-segment displays; control inputs come from debounced keys or a host block.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per one-second tick; legal range ≥2.
- `MIN_MAX`, default 99: highest minute value; legal range 1..99.
- `SEG_ACTIVE_LOW`, default 1: 1 means a segment is lit when its bit is 0.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled; enter RUN.
- `stop`  in  1  level-sampled; pause.
- `clear`  in  1  level-sampled; zero all digits and go to IDLE.
- `up_ndown`  in  1  1 counts up, 0 counts down; sampled on every tick.
- `load`  in  1  single-cycle strobe; preset the digits from `load_min` and `load_sec`.
- `load_min`  in  8  BCD minutes, tens digit in [7:4].
- `load_sec`  in  8  BCD seconds, tens digit in [7:4].
- `sec1`, `sec2`, `min1`, `min2`  out  7 each  segment patterns {g,f,e,d,c,b,a}: seconds units, seconds tens, minutes units, minutes tens.
- `running`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when a count-down reaches 00:00.
- `wrap`  out  1  one-cycle pulse when a count-up rolls over from MIN_MAX:59 to 00:00.
- `load_err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- **States**
  - IDLE: stopped, digits held.
  - RUN: counting.
  - DONE: count-down finished, digits held at 00:00.
- **Command priority per cycle:** clear > load > stop > start.
  - clear: from any state, digits := 0, prescaler := 0, go to IDLE.
  - load: allowed in any state; the state is kept, except DONE goes to IDLE. Prescaler := 0.
  - stop: RUN goes to IDLE. The prescaler keeps its value, so the tick phase resumes on restart.
  - start:
    - From IDLE, go to RUN, except when down mode is selected and the digits are 00:00; then go to DONE and pulse `done`.
    - From DONE, start is ignored.
- **Load validation:** reject the load if any nibble is >9, the seconds tens digit is >5, or the minutes value is >MIN_MAX. On rejection, `load_err` pulses and the digits stay unchanged.
- **Prescaler:** width $clog2(TICK_DIV). It increments only in RUN. At TICK_DIV-1 it produces an internal tick and returns to 0.
- **On tick, up mode:** BCD increment.
  - Seconds units 9→0 carries into seconds tens.
  - Seconds tens 5→0 carries into minutes.
  - Minutes at MIN_MAX roll to 00 together with the seconds; `wrap` pulses and counting continues.
- **On tick, down mode:** BCD decrement with borrows (00:00 side: seconds 00→59, minutes decrement). On reaching 00:00, go to DONE and pulse `done` in the same update cycle.
- **Mode switch mid-run:** takes effect on the next tick. There is no prescaler reset.
- **Segment encoding:** each digit is converted to 7-segment; the pattern is inverted when SEG_ACTIVE_LOW=0. Digit codes above 9 cannot occur.

## Timing
- **Reset:** digits 0, prescaler 0, state IDLE; `running`, `done`, `wrap` and `load_err` are 0. All four segment outputs show "0" (7'b1000000 when active-low).
- **Tick to display:** the digit registers update on the edge after the prescaler reaches TICK_DIV-1. Segment outputs follow one edge later, so each segment output is registered with 1-cycle latency from its digit.
- **Event pulses:** `done`, `wrap` and `load_err` are registered and assert in the same cycle as the corresponding digit update.
- **Running flag:** `running` is asserted the edge after start is accepted.
- **Reset mid-operation:** all state is lost immediately (asynchronous); there is no partial update.
- **Simultaneous tick and command:** clear or load wins over the tick, and the tick is discarded.

## Structure
- **Package `contador_pkg`:**
  - State enum (IDLE, RUN, DONE).
  - 7-segment active-low constants for 0–9.
  - BCD digit typedef (4 bits).
- **Sub-module `bcd_to_7seg`:** one digit, parameter ACTIVE_LOW, registered output. Instantiated four times.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, then start in up mode for 4×60 cycles → digits read 01:00; `sec1`/`sec2`/`min1`/`min2` = "0","0","1","0".
- MIN_MAX=2, load 02:59, up mode, start, one tick → 00:00 and `wrap` pulses exactly once.
- Load 00:02, down mode, start → 00:01, then 00:00 with one `done` pulse; state DONE, `running`=0, further ticks do not change the digits.
- Load with sec=8'h60 → `load_err` pulses and the digits are unchanged. Load with min=8'h1A → rejected.
- Stop after 2 prescaler cycles, wait 10 cycles, start → next tick occurs after 2 more running cycles. Assert clear and start together → IDLE, 00:00.
- Assert rst_n=0 mid-run, asynchronously between edges → outputs show "0" immediately; `running`=0.
